// File: rtl/ext_interrupt_controller.sv
// rtl/ext_interrupt_controller.sv - external interrupt controller with priority arbitration and claim/complete
//
// Purpose
//   Collects NUM_SRC external interrupt sources, latches them into a pending
//   register (per-source level or rising-edge mode), and arbitrates among the
//   eligible ones (pending, enabled, not in service, priority above threshold).
//   The winner is registered as a claim ID (source index + 1, 0 = none), which
//   drives the MEIP request. A claim moves the winner from pending to
//   in-service and pulses a one-cycle ack to that source. A complete returns
//   the source from in-service.
//
// Ports
//   clk                         in   clock
//   rst                         in   synchronous reset, active high
//   all_extintc_src_req         in   raw source request lines (synchronous to clk)
//   csrf_extintc_enable         in   per-source enable
//   csrf_extintc_edge_mode      in   per-source mode, 1 = rising edge, 0 = level
//   csrf_extintc_priority       in   packed per-source priorities, PRIO_WIDTH each
//   csrf_extintc_threshold      in   global threshold, eligible only if prio > threshold
//   extintc_csrf_pending        out  pending register
//   extintc_csrf_in_service     out  claimed-but-not-completed register
//   extintc_intif_ext_req       out  1 when an eligible source exists
//   extintc_commit_claim_id     out  ID of the best eligible source, 0 = none
//   commit_extintc_claim        in   claim pulse, claims extintc_commit_claim_id
//   commit_extintc_complete     in   complete pulse
//   commit_extintc_complete_id  in   ID being completed
//   extintc_all_src_ack         out  one-hot ack pulse to the claimed source

module ext_interrupt_controller #(
  parameter int NUM_SRC    = 8,
  parameter int PRIO_WIDTH = 3,
  parameter int ID_WIDTH   = $clog2(NUM_SRC + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            all_extintc_src_req,
  input  logic [NUM_SRC-1:0]            csrf_extintc_enable,
  input  logic [NUM_SRC-1:0]            csrf_extintc_edge_mode,
  input  logic [NUM_SRC*PRIO_WIDTH-1:0] csrf_extintc_priority,
  input  logic [PRIO_WIDTH-1:0]         csrf_extintc_threshold,
  output logic [NUM_SRC-1:0]            extintc_csrf_pending,
  output logic [NUM_SRC-1:0]            extintc_csrf_in_service,
  output logic                          extintc_intif_ext_req,
  output logic [ID_WIDTH-1:0]           extintc_commit_claim_id,
  input  logic                          commit_extintc_claim,
  input  logic                          commit_extintc_complete,
  input  logic [ID_WIDTH-1:0]           commit_extintc_complete_id,
  output logic [NUM_SRC-1:0]            extintc_all_src_ack
);

  // Registered state
  logic [NUM_SRC-1:0]  pending_q,    pending_d;
  logic [NUM_SRC-1:0]  in_service_q, in_service_d;
  logic [NUM_SRC-1:0]  src_prev_q,   src_prev_d;
  logic [NUM_SRC-1:0]  ack_q,        ack_d;
  logic                ext_req_q,    ext_req_d;
  logic [ID_WIDTH-1:0] claim_id_q,   claim_id_d;

  // Combinational helpers
  logic [NUM_SRC-1:0]    claim_hit;
  logic [NUM_SRC-1:0]    complete_hit;
  logic [NUM_SRC-1:0]    edge_det;
  logic [NUM_SRC-1:0]    pend_set;
  logic [NUM_SRC-1:0]    eligible;
  logic [PRIO_WIDTH-1:0] src_prio [NUM_SRC];
  logic [PRIO_WIDTH-1:0] best_prio;
  logic [ID_WIDTH-1:0]   best_id;

  // Claim/complete decode. A claim only targets the ID currently on
  // claim_id_q, so claim_id_q == 0 matches no source and is a no-op.
  // A complete is honoured only for a valid ID whose source is in service;
  // IDs of 0 or above NUM_SRC never match any bit.
  always_comb begin
    claim_hit    = '0;
    complete_hit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      claim_hit[i]    = commit_extintc_claim &&
                        (claim_id_q == ID_WIDTH'(i + 1));
      complete_hit[i] = commit_extintc_complete &&
                        (commit_extintc_complete_id == ID_WIDTH'(i + 1)) &&
                        in_service_q[i];
    end
  end

  // Pending update.
  // Edge sources set on a rising edge regardless of service state, and a new
  // edge coinciding with the claim keeps the bit set (set beats clear).
  // Level sources set only while not in service; the claim clear wins over a
  // still-high level request so the claimed source does not re-pend at once.
  always_comb begin
    edge_det  = all_extintc_src_req & ~src_prev_q;
    pend_set  = (csrf_extintc_edge_mode & edge_det) |
                (~csrf_extintc_edge_mode & all_extintc_src_req &
                 ~in_service_q & ~claim_hit);
    pending_d = (pending_q & ~claim_hit) | pend_set;
  end

  // Complete is applied before claim, so a same-cycle pair on one source
  // leaves it in service.
  always_comb begin
    in_service_d = (in_service_q & ~complete_hit) | claim_hit;
    src_prev_d   = all_extintc_src_req;
    ack_d        = claim_hit;
  end

  // Eligibility from registered state and current configuration.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_prio[i] = csrf_extintc_priority[i*PRIO_WIDTH +: PRIO_WIDTH];
      eligible[i] = pending_q[i] & csrf_extintc_enable[i] & ~in_service_q[i] &
                    (src_prio[i] > csrf_extintc_threshold);
    end
  end

  // Priority arbitration. Scanning upward with a strict '>' keeps the lowest
  // index on a tie. An eligible source always has priority >= 1, so starting
  // best_prio at 0 never lets an ineligible source win.
  always_comb begin
    best_prio = '0;
    best_id   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (eligible[i] && (src_prio[i] > best_prio)) begin
        best_prio = src_prio[i];
        best_id   = ID_WIDTH'(i + 1);
      end
    end
    claim_id_d = best_id;
    ext_req_d  = (best_id != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q    <= '0;
      in_service_q <= '0;
      src_prev_q   <= '0;
      ack_q        <= '0;
      ext_req_q    <= 1'b0;
      claim_id_q   <= '0;
    end else begin
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      src_prev_q   <= src_prev_d;
      ack_q        <= ack_d;
      ext_req_q    <= ext_req_d;
      claim_id_q   <= claim_id_d;
    end
  end

  assign extintc_csrf_pending    = pending_q;
  assign extintc_csrf_in_service = in_service_q;
  assign extintc_intif_ext_req   = ext_req_q;
  assign extintc_commit_claim_id = claim_id_q;
  assign extintc_all_src_ack     = ack_q;

endmodule

// File: tb/tb_ext_interrupt_controller.sv
// tb/tb_ext_interrupt_controller.sv - directed self-checking bench for ext_interrupt_controller

module tb_ext_interrupt_controller;

  localparam int NUM_SRC    = 8;
  localparam int PRIO_WIDTH = 3;
  localparam int ID_WIDTH   = 4;

  logic                          clk = 1'b0;
  logic                          rst;
  logic [NUM_SRC-1:0]            req;
  logic [NUM_SRC-1:0]            en;
  logic [NUM_SRC-1:0]            edge_m;
  logic [NUM_SRC*PRIO_WIDTH-1:0] prio;
  logic [PRIO_WIDTH-1:0]         thr;
  logic [NUM_SRC-1:0]            pending;
  logic [NUM_SRC-1:0]            in_service;
  logic                          ext_req;
  logic [ID_WIDTH-1:0]           claim_id;
  logic                          claim;
  logic                          complete;
  logic [ID_WIDTH-1:0]           complete_id;
  logic [NUM_SRC-1:0]            ack;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ext_interrupt_controller #(
    .NUM_SRC(NUM_SRC),
    .PRIO_WIDTH(PRIO_WIDTH)
  ) dut (
    .clk                        (clk),
    .rst                        (rst),
    .all_extintc_src_req        (req),
    .csrf_extintc_enable        (en),
    .csrf_extintc_edge_mode     (edge_m),
    .csrf_extintc_priority      (prio),
    .csrf_extintc_threshold     (thr),
    .extintc_csrf_pending       (pending),
    .extintc_csrf_in_service    (in_service),
    .extintc_intif_ext_req      (ext_req),
    .extintc_commit_claim_id    (claim_id),
    .commit_extintc_claim       (claim),
    .commit_extintc_complete    (complete),
    .commit_extintc_complete_id (complete_id),
    .extintc_all_src_ack        (ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_prio(input int idx, input logic [PRIO_WIDTH-1:0] v);
    prio[idx*PRIO_WIDTH +: PRIO_WIDTH] = v;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pending"},  64'(pending),    64'h0);
    check({tag, "_inserv"},   64'(in_service), 64'h0);
    check({tag, "_ext_req"},  64'(ext_req),    64'h0);
    check({tag, "_claim_id"}, 64'(claim_id),   64'h0);
    check({tag, "_ack"},      64'(ack),        64'h0);
  endtask

  initial begin
    // ---------------- T1 reset ----------------
    rst = 1'b1; req = 8'hFF; en = 8'hFF; edge_m = 8'h00; thr = '0;
    claim = 1'b0; complete = 1'b0; complete_id = '0;
    prio = '0;
    for (int i = 0; i < NUM_SRC; i++) set_prio(i, 3'd1);
    tick(); tick();
    check_all_zero("t1_reset");
    rst = 1'b0;
    tick();
    check("t1_pend_after_rel", 64'(pending), 64'hFF);
    check("t1_extreq_k",       64'(ext_req), 64'h0);
    tick();
    check("t1_extreq_k1",  64'(ext_req),  64'h1);
    check("t1_claimid_k1", 64'(claim_id), 64'h1);

    // ---------------- T2 priority / tie ----------------
    rst = 1'b1; req = 8'h26; prio = '0;
    set_prio(1, 3'd3); set_prio(2, 3'd5); set_prio(5, 3'd5);
    tick();
    rst = 1'b0;
    tick();
    check("t2_pending", 64'(pending), 64'h26);
    tick();
    check("t2_tie_claim_id", 64'(claim_id), 64'h3);
    check("t2_ext_req",      64'(ext_req),  64'h1);
    en = 8'hFB;
    tick();
    check("t2_dis_claim_id", 64'(claim_id), 64'h6);
    check("t2_dis_pending",  64'(pending),  64'h26);

    // ---------------- T3 claim / complete ----------------
    en = 8'hFF;
    tick();
    check("t3_pre_claim_id", 64'(claim_id), 64'h3);
    claim = 1'b1;
    tick();
    claim = 1'b0;
    check("t3_ack1",      64'(ack),        64'h04);
    check("t3_inserv1",   64'(in_service), 64'h04);
    check("t3_pending1",  64'(pending),    64'h22);
    check("t3_id_hold",   64'(claim_id),   64'h3);
    tick();
    check("t3_ack1_gone", 64'(ack),        64'h00);
    check("t3_next_id",   64'(claim_id),   64'h6);
    claim = 1'b1;
    tick();
    claim = 1'b0;
    check("t3_ack2",    64'(ack),        64'h20);
    check("t3_inserv2", 64'(in_service), 64'h24);
    tick();
    check("t3_id_src1", 64'(claim_id), 64'h2);
    complete = 1'b1; complete_id = 4'd3;
    tick();
    complete = 1'b0; complete_id = '0;
    check("t3_inserv_cmp", 64'(in_service), 64'h20);
    tick();
    check("t3_repend", 64'(pending), 64'h06);
    tick();
    check("t3_id_back", 64'(claim_id), 64'h3);

    // ---------------- T4 edge mode ----------------
    rst = 1'b1; req = 8'h00; edge_m = 8'h10; prio = '0; set_prio(4, 3'd2);
    tick();
    rst = 1'b0;
    tick();
    req = 8'h10;
    tick();
    req = 8'h00;
    check("t4_pend_pulse", 64'(pending), 64'h10);
    tick();
    check("t4_pend_persist", 64'(pending),  64'h10);
    check("t4_claim_id",     64'(claim_id), 64'h5);
    claim = 1'b1;
    tick();
    claim = 1'b0;
    check("t4_ack",     64'(ack),        64'h10);
    check("t4_pend_cl", 64'(pending),    64'h00);
    check("t4_inserv",  64'(in_service), 64'h10);
    req = 8'h10;
    tick();
    req = 8'h00;
    tick();
    check("t4_pend_in_srv", 64'(pending),  64'h10);
    check("t4_id_in_srv",   64'(claim_id), 64'h0);
    check("t4_req_in_srv",  64'(ext_req),  64'h0);
    complete = 1'b1; complete_id = 4'd5;
    tick();
    complete = 1'b0; complete_id = '0;
    tick();
    check("t4_id_after_cmp", 64'(claim_id), 64'h5);
    claim = 1'b1; req = 8'h10;
    tick();
    claim = 1'b0; req = 8'h00;
    check("t4_edge_wins_pend", 64'(pending), 64'h10);
    check("t4_edge_wins_ack",  64'(ack),     64'h10);

    // ---------------- T5 threshold / masking ----------------
    rst = 1'b1; req = 8'h27; edge_m = 8'h00; en = 8'hFF; thr = 3'd5;
    prio = '0; set_prio(1, 3'd3); set_prio(2, 3'd5); set_prio(5, 3'd5);
    tick();
    rst = 1'b0;
    tick(); tick();
    check("t5_thr5_pending",  64'(pending),  64'h27);
    check("t5_thr5_ext_req",  64'(ext_req),  64'h0);
    check("t5_thr5_claim_id", 64'(claim_id), 64'h0);
    thr = 3'd4;
    tick();
    check("t5_thr4_claim_id", 64'(claim_id), 64'h3);
    thr = 3'd0; en = 8'h01;
    tick();
    check("t5_prio0_claim_id", 64'(claim_id), 64'h0);
    check("t5_prio0_pending",  64'(pending),  64'h27);
    thr = 3'd4; en = 8'hFF;
    tick();
    claim = 1'b1;
    tick();
    claim = 1'b0;
    check("t5_claim_inserv", 64'(in_service), 64'h04);
    complete = 1'b1; complete_id = 4'd0;
    tick();
    complete_id = 4'd9;
    tick();
    complete_id = 4'd2;
    tick();
    complete = 1'b0; complete_id = '0;
    check("t5_bogus_inserv",  64'(in_service), 64'h04);
    check("t5_bogus_pending", 64'(pending),    64'h23);
    check("t5_bogus_id",      64'(claim_id),   64'h6);

    // ---------------- T6 reset mid-operation ----------------
    rst = 1'b1; claim = 1'b1;
    tick();
    rst = 1'b0; claim = 1'b0;
    check_all_zero("t6_mid_reset");
    tick();
    check("t6_repend", 64'(pending), 64'h27);
    check("t6_no_ack", 64'(ack),     64'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
